bcd_time_keeper: RTL and testbench



---
 rtl/bcd_time_keeper.sv | 181 ++++++++++++++++++
 tb/tb_bcd_time_keeper.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_time_keeper.sv
// HH:MM:SS BCD timekeeper on a single clock: 1 Hz tick, debounced set button
// with short/long press detection, and a packed BCD time word with update strobe.
module bcd_time_keeper #(
    parameter int CLK_HZ            = 12000000,
    parameter int DEBOUNCE_CYCLES   = 120000,
    parameter int LONG_PRESS_CYCLES = 24000000
) (
    input  logic        hwclk,
    input  logic        reset,
    input  logic        btn,
    output logic [23:0] time_bcd,
    output logic [1:0]  set_mode,
    output logic        updated,
    output logic        sec_tick
);

    typedef enum logic [1:0] {
        MODE_RUN   = 2'd0,
        MODE_SET_H = 2'd1,
        MODE_SET_M = 2'd2
    } mode_t;

    localparam int TICK_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_HZ - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

    // Two-digit BCD increment modulo 60; returns {carry, next value}.
    function automatic logic [8:0] inc_mod60(input logic [7:0] v);
        if (v[3:0] != 4'd9)
            return {1'b0, v[7:4], v[3:0] + 4'd1};
        if (v[7:4] != 4'd5)
            return {1'b0, v[7:4] + 4'd1, 4'd0};
        return 9'h100;
    endfunction

    function automatic logic [7:0] inc_hours(input logic [7:0] v);
        if (v == 8'h23)
            return 8'h00;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    logic [TICK_W-1:0] tick_cnt;
    logic              btn_meta;
    logic              btn_sync;
    logic              btn_deb;
    logic              btn_deb_q;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    mode_t             mode;
    logic [7:0]        hours;
    logic [7:0]        minutes;
    logic [7:0]        seconds;

    logic              long_evt;
    logic              short_evt;
    logic              tick_clr;
    logic              sec_carry;
    logic              min_carry;
    logic [7:0]        sec_inc;
    logic [7:0]        min_inc;
    logic [7:0]        hour_inc;

    assign {sec_carry, sec_inc} = inc_mod60(seconds);
    assign {min_carry, min_inc} = inc_mod60(minutes);
    assign hour_inc             = inc_hours(hours);

    assign sec_tick = (tick_cnt == TICK_LAST);
    assign tick_clr = (mode == MODE_SET_M) && long_evt;

    // long_evt can only occur once per hold because hold_cnt saturates past HOLD_LAST.
    assign long_evt  = btn_deb && (hold_cnt == HOLD_LAST);
    assign short_evt = btn_deb_q && !btn_deb && (hold_cnt != HOLD_MAX);

    assign time_bcd = {hours, minutes, seconds};
    assign set_mode = mode;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick_clr || sec_tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            btn_meta <= btn;
            btn_sync <= btn_meta;
        end
    end

    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            btn_deb   <= 1'b0;
            btn_deb_q <= 1'b0;
            db_cnt    <= '0;
        end else begin
            btn_deb_q <= btn_deb;
            if (btn_sync == btn_deb) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                btn_deb <= ~btn_deb;
                db_cnt  <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            hold_cnt <= '0;
        end else if (!btn_deb) begin
            hold_cnt <= '0;
        end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    // Every accepted event changes time or mode, so updated mirrors event acceptance.
    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            mode    <= MODE_RUN;
            hours   <= 8'h00;
            minutes <= 8'h00;
            seconds <= 8'h00;
            updated <= 1'b0;
        end else begin
            case (mode)
                MODE_RUN: begin
                    if (sec_tick) begin
                        seconds <= sec_inc;
                        if (sec_carry) begin
                            minutes <= min_inc;
                            if (min_carry)
                                hours <= hour_inc;
                        end
                    end
                    if (long_evt)
                        mode <= MODE_SET_H;
                    updated <= sec_tick || long_evt;
                end
                MODE_SET_H: begin
                    if (short_evt)
                        hours <= hour_inc;
                    if (long_evt)
                        mode <= MODE_SET_M;
                    updated <= short_evt || long_evt;
                end
                MODE_SET_M: begin
                    if (short_evt)
                        minutes <= min_inc;
                    if (long_evt) begin
                        mode    <= MODE_RUN;
                        seconds <= 8'h00;
                    end
                    updated <= short_evt || long_evt;
                end
                default: begin
                    mode    <= MODE_RUN;
                    updated <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_time_keeper.sv
// Randomized bench for bcd_time_keeper: scenario tasks compare the DUT against
// a cycle-level reference that keeps time as plain integers.
module tb_bcd_time_keeper;

    localparam int CLK_HZ = 10;
    localparam int DEB    = 4;
    localparam int LONG   = 20;

    logic        hwclk = 1'b0;
    logic        reset;
    logic        btn;
    logic [23:0] time_bcd;
    logic [1:0]  set_mode;
    logic        updated;
    logic        sec_tick;

    int checks = 0;
    int errors = 0;

    bcd_time_keeper #(
        .CLK_HZ            (CLK_HZ),
        .DEBOUNCE_CYCLES   (DEB),
        .LONG_PRESS_CYCLES (LONG)
    ) dut (
        .hwclk    (hwclk),
        .reset    (reset),
        .btn      (btn),
        .time_bcd (time_bcd),
        .set_mode (set_mode),
        .updated  (updated),
        .sec_tick (sec_tick)
    );

    always #5 hwclk = ~hwclk;

    // Reference state after each rising edge.
    int m_h = 0, m_m = 0, m_s = 0, m_mode = 0, m_phase = 0, m_run = 0, m_hold = 0;
    bit m_upd = 0, m_s1 = 0, m_s2 = 0, m_deb = 0, m_deb_q = 0, m_long_done = 0;

    function automatic logic [23:0] exp_bcd(input int h, input int m, input int s);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    always @(posedge hwclk or posedge reset) begin : ref_model
        bit tick_now, lng, shrt;
        int total, old_mode, old_h, old_m, old_s;
        if (reset) begin
            m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_phase = 0; m_run = 0; m_hold = 0;
            m_upd = 0; m_s1 = 0; m_s2 = 0; m_deb = 0; m_deb_q = 0; m_long_done = 0;
        end else begin
            tick_now = (m_phase == CLK_HZ - 1);
            lng      = m_deb && (m_hold == LONG - 1);
            shrt     = m_deb_q && !m_deb && !m_long_done;
            old_mode = m_mode; old_h = m_h; old_m = m_m; old_s = m_s;
            case (m_mode)
                0: begin
                    if (tick_now) begin
                        total = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
                        m_h = total / 3600;
                        m_m = (total / 60) % 60;
                        m_s = total % 60;
                    end
                    if (lng) m_mode = 1;
                end
                1: begin
                    if (shrt) m_h = (m_h + 1) % 24;
                    if (lng) m_mode = 2;
                end
                default: begin
                    if (shrt) m_m = (m_m + 1) % 60;
                    if (lng) begin m_mode = 0; m_s = 0; end
                end
            endcase
            m_upd   = (m_mode != old_mode) || (m_h != old_h) || (m_m != old_m) || (m_s != old_s);
            m_phase = (old_mode == 2 && lng) ? 0 : (m_phase + 1) % CLK_HZ;
            if (m_deb && !m_deb_q) m_long_done = 0;
            if (lng) m_long_done = 1;
            m_hold  = m_deb ? m_hold + 1 : 0;
            m_deb_q = m_deb;
            if (m_s2 != m_deb) begin
                m_run++;
                if (m_run == DEB) begin m_deb = !m_deb; m_run = 0; end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = btn;
        end
    end

    task automatic apply_reset();
        @(negedge hwclk);
        reset = 1'b1;
        repeat (2) @(negedge hwclk);
        reset = 1'b0;
    endtask

    task automatic press(input int hi, input int lo);
        btn = 1'b1;
        repeat (hi) @(negedge hwclk);
        btn = 1'b0;
        repeat (lo) @(negedge hwclk);
    endtask

    task automatic short_press();
        press($urandom_range(15, 5), $urandom_range(12, 8));
    endtask

    task automatic long_press();
        press(30, 10);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge hwclk);
        checks++; if (time_bcd !== 24'h000000) begin errors++; $display("FAIL reset_time: got %h expected 000000", time_bcd); end
        checks++; if (set_mode !== 2'd0) begin errors++; $display("FAIL reset_mode: got %0d expected 0", set_mode); end
        checks++; if (updated !== 1'b0) begin errors++; $display("FAIL reset_updated: got %b expected 0", updated); end
        checks++; if (sec_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", sec_tick); end
    endtask

    task automatic test_run_600();
        int ticks = 0, upds = 0, last_tick = -1, bad_gap = 0;
        apply_reset();
        for (int i = 1; i <= 600; i++) begin
            @(negedge hwclk);
            checks++; if (time_bcd !== exp_bcd(m_h, m_m, m_s)) begin errors++; $display("FAIL run_time cyc %0d: got %h expected %h", i, time_bcd, exp_bcd(m_h, m_m, m_s)); end
            checks++; if (updated !== m_upd) begin errors++; $display("FAIL run_updated cyc %0d: got %b expected %b", i, updated, m_upd); end
            checks++; if (sec_tick !== (m_phase == CLK_HZ - 1)) begin errors++; $display("FAIL run_tick cyc %0d: got %b expected %b", i, sec_tick, m_phase == CLK_HZ - 1); end
            checks++; if ({time_bcd[23:22], time_bcd[15], time_bcd[7]} !== 4'b0000) begin errors++; $display("FAIL run_unused_bits cyc %0d: got %h expected 0 in unused bits", i, time_bcd); end
            if (sec_tick) begin
                if (last_tick >= 0 && i - last_tick != CLK_HZ) bad_gap++;
                last_tick = i;
                ticks++;
            end
            if (updated) upds++;
        end
        checks++; if (ticks != 60) begin errors++; $display("FAIL run_tick_count: got %0d expected 60", ticks); end
        checks++; if (upds != 60) begin errors++; $display("FAIL run_updated_count: got %0d expected 60", upds); end
        checks++; if (bad_gap != 0) begin errors++; $display("FAIL run_tick_spacing: got %0d bad gaps expected 0", bad_gap); end
        checks++; if (time_bcd !== 24'h000100) begin errors++; $display("FAIL run_final_time: got %h expected 000100", time_bcd); end
    endtask

    task automatic test_glitch();
        bit level = 1'b0;
        bit prev_tick;
        int run_left = 0, btn_upd = 0;
        prev_tick = sec_tick;
        for (int i = 0; i < 98; i++) begin
            if (i < 90) begin
                if (run_left == 0) begin
                    level    = !level;
                    run_left = level ? $urandom_range(DEB - 1, 1) : $urandom_range(2, 1);
                end
                run_left--;
                btn = level;
            end else begin
                btn = 1'b0;
            end
            @(negedge hwclk);
            checks++; if (set_mode !== 2'd0) begin errors++; $display("FAIL glitch_mode cyc %0d: got %0d expected 0", i, set_mode); end
            checks++; if (updated !== m_upd) begin errors++; $display("FAIL glitch_updated cyc %0d: got %b expected %b", i, updated, m_upd); end
            if (updated && !prev_tick) btn_upd++;
            prev_tick = sec_tick;
        end
        checks++; if (btn_upd != 0) begin errors++; $display("FAIL glitch_btn_updates: got %0d expected 0", btn_upd); end
        checks++; if (time_bcd !== exp_bcd(m_h, m_m, m_s)) begin errors++; $display("FAIL glitch_time: got %h expected %h", time_bcd, exp_bcd(m_h, m_m, m_s)); end
    endtask

    task automatic test_set_hours();
        int k = 0, bad_time = 0, frozen_upd = 0, frozen_ticks = 0;
        apply_reset();
        btn = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge hwclk);
            if (set_mode == 2'd1) begin k = i; break; end
        end
        checks++; if (k != 2 + DEB + LONG) begin errors++; $display("FAIL set_h_entry_latency: got %0d expected %0d", k, 2 + DEB + LONG); end
        repeat (30 - k) @(negedge hwclk);
        btn = 1'b0;
        repeat (12) @(negedge hwclk);
        repeat (3) short_press();
        checks++; if (time_bcd !== 24'h030002) begin errors++; $display("FAIL set_h_hours: got %h expected 030002", time_bcd); end
        checks++; if (set_mode !== 2'd1) begin errors++; $display("FAIL set_h_mode: got %0d expected 1", set_mode); end
        checks++; if (time_bcd !== exp_bcd(m_h, m_m, m_s)) begin errors++; $display("FAIL set_h_model: got %h expected %h", time_bcd, exp_bcd(m_h, m_m, m_s)); end
        for (int i = 0; i < 50; i++) begin
            @(negedge hwclk);
            if (time_bcd !== 24'h030002) bad_time++;
            if (updated) frozen_upd++;
            if (sec_tick) frozen_ticks++;
        end
        checks++; if (bad_time != 0) begin errors++; $display("FAIL set_h_frozen_time: got %0d changed cycles expected 0", bad_time); end
        checks++; if (frozen_upd != 0) begin errors++; $display("FAIL set_h_frozen_updated: got %0d pulses expected 0", frozen_upd); end
        checks++; if (frozen_ticks != 5) begin errors++; $display("FAIL set_h_ignored_ticks: got %0d expected 5", frozen_ticks); end
    endtask

    task automatic test_set_minutes();
        int k = 0, j = 0;
        long_press();
        checks++; if (set_mode !== 2'd2) begin errors++; $display("FAIL set_m_entry: got %0d expected 2", set_mode); end
        repeat (61) short_press();
        checks++; if (time_bcd !== 24'h030102) begin errors++; $display("FAIL set_m_wrap: got %h expected 030102", time_bcd); end
        checks++; if (time_bcd !== exp_bcd(m_h, m_m, m_s)) begin errors++; $display("FAIL set_m_model: got %h expected %h", time_bcd, exp_bcd(m_h, m_m, m_s)); end
        btn = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge hwclk);
            if (set_mode == 2'd0) begin k = i; break; end
        end
        checks++; if (k != 2 + DEB + LONG) begin errors++; $display("FAIL set_m_exit_latency: got %0d expected %0d", k, 2 + DEB + LONG); end
        checks++; if (time_bcd !== 24'h030100) begin errors++; $display("FAIL set_m_exit_time: got %h expected 030100", time_bcd); end
        checks++; if (updated !== 1'b1) begin errors++; $display("FAIL set_m_exit_updated: got %b expected 1", updated); end
        // Mode change is visible one cycle after the long_evt cycle, so 9 more gives 10 total.
        for (int i = 1; i <= 20; i++) begin
            @(negedge hwclk);
            if (sec_tick) begin j = i; break; end
        end
        checks++; if (j != CLK_HZ - 1) begin errors++; $display("FAIL set_m_first_tick: got %0d expected %0d", j, CLK_HZ - 1); end
        btn = 1'b0;
        repeat (10) @(negedge hwclk);
        checks++; if (set_mode !== 2'd0) begin errors++; $display("FAIL set_m_release_after_long: got %0d expected 0", set_mode); end
    endtask

    task automatic test_wrap();
        int k = 0, n = 0;
        apply_reset();
        long_press();
        repeat (23) short_press();
        long_press();
        repeat (59) short_press();
        btn = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge hwclk);
            if (set_mode == 2'd0) begin k = i; break; end
        end
        checks++; if (time_bcd !== 24'h235900 || k == 0) begin errors++; $display("FAIL wrap_preload: got %h mode %0d expected 235900 mode 0", time_bcd, set_mode); end
        for (int i = 1; i <= 700; i++) begin
            @(negedge hwclk);
            if (i == 5) btn = 1'b0;
            if (updated) begin
                n++;
                if (n == 59) begin
                    checks++; if (time_bcd !== 24'h235959) begin errors++; $display("FAIL wrap_235959: got %h expected 235959", time_bcd); end
                end
                if (n == 60) begin
                    checks++; if (time_bcd !== 24'h000000) begin errors++; $display("FAIL wrap_midnight: got %h expected 000000", time_bcd); end
                    break;
                end
            end
        end
        checks++; if (n != 60) begin errors++; $display("FAIL wrap_update_count: got %0d expected 60", n); end
        checks++; if (time_bcd !== exp_bcd(m_h, m_m, m_s)) begin errors++; $display("FAIL wrap_model: got %h expected %h", time_bcd, exp_bcd(m_h, m_m, m_s)); end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        long_press();
        short_press();
        long_press();
        checks++; if (set_mode !== 2'd2 || set_mode !== 2'(m_mode)) begin errors++; $display("FAIL mid_pre_mode: got %0d expected 2", set_mode); end
        btn = 1'b1;
        repeat (8) @(negedge hwclk);
        #2 reset = 1'b1;
        #1;
        checks++; if (time_bcd !== 24'h000000) begin errors++; $display("FAIL mid_reset_time: got %h expected 000000", time_bcd); end
        checks++; if (set_mode !== 2'd0) begin errors++; $display("FAIL mid_reset_mode: got %0d expected 0", set_mode); end
        checks++; if (updated !== 1'b0) begin errors++; $display("FAIL mid_reset_updated: got %b expected 0", updated); end
        @(negedge hwclk);
        reset = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge hwclk);
            if (set_mode == 2'd1) begin k = i; break; end
        end
        checks++; if (k != 2 + DEB + LONG) begin errors++; $display("FAIL mid_fresh_press_latency: got %0d expected %0d", k, 2 + DEB + LONG); end
        checks++; if (time_bcd !== 24'h000002) begin errors++; $display("FAIL mid_fresh_press_time: got %h expected 000002", time_bcd); end
        checks++; if (updated !== 1'b1) begin errors++; $display("FAIL mid_fresh_press_updated: got %b expected 1", updated); end
        btn = 1'b0;
        repeat (10) @(negedge hwclk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t expected completion", $time);
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        btn   = 1'b0;
        #1 reset = 1'b1;
        test_reset();
        test_run_600();
        test_glitch();
        test_set_hours();
        test_set_minutes();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
